alu_writeback: RTL and testbench
================================

# alu_writeback

Writeback stage directly downstream of the ALU. Captures one ALU result pair (Y1, Y2) per accepted transaction, then serialises it onto the register file's single write port as up to two writes, Y1 first. Register-file port access is arbitrated through a request/grant pair. A valid/ready handshake back-pressures the issue logic feeding the ALU.

## Interface
- DATA_W, 32, width of each result word (Y1, Y2)
- ADDR_W, 5, register index width; index 0 is the hardwired zero register
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  ALU result pair and destinations are valid
- in_ready  output  1  stage can accept a transaction this cycle
- Y1  input  DATA_W  first ALU result word
- Y2  input  DATA_W  second ALU result word
- en1  input  1  Y1 is to be written
- en2  input  1  Y2 is to be written
- dest1  input  ADDR_W  destination register for Y1
- dest2  input  ADDR_W  destination register for Y2
- rf_we  output  1  write request to register file
- rf_waddr  output  ADDR_W  write address
- rf_wdata  output  DATA_W  write data
- rf_grant  input  1  register file accepts the current write this cycle
- wb_done  output  1  one-cycle pulse: previous transaction fully retired
- busy  output  1  a captured transaction still has writes outstanding

## Operation
- A transaction is accepted on a rising edge where in_valid && in_ready. Y1, Y2, dest1, dest2 and the effective enables are captured.
- Effective enables: w1 = en1 && dest1 != 0; w2 = en2 && dest2 != 0. Writes to r0 are dropped and take no cycle.
- FSM states: IDLE, WR1, WR2.
  - IDLE, accept: go to WR1 if w1; else WR2 if w2; else stay IDLE and pulse wb_done next cycle.
  - WR1: rf_we=1, rf_waddr=dest1, rf_wdata=Y1. On rf_grant, go to WR2 if w2, else retire.
  - WR2: rf_we=1, rf_waddr=dest2, rf_wdata=Y2. On rf_grant, retire.
  - Retire: go to IDLE. If a new transaction is accepted in the same cycle, take that transaction's first state instead.
- rf_we, rf_waddr and rf_wdata are held stable while rf_grant is low. There is no timeout.
- If dest1 == dest2 with both written, both writes occur in order, so the register ends holding Y2.
- in_ready = (state==IDLE) || (rf_grant && final write of current transaction is being granted). This is a combinational path from rf_grant.
- busy = (state != IDLE).
- Y1/Y2 are captured regardless of the precision the ALU used. DOUBLE results arrive as a pre-split pair and need no special handling.

## Timing
- Reset values:
  - state=IDLE, rf_we=0, rf_waddr=0, rf_wdata=0, wb_done=0, busy=0.
  - in_ready=1 from the first cycle after reset.
- Reset asserted mid-transaction discards all outstanding writes. No write is issued in the reset cycle or afterwards.
- Latency: first rf_we is 1 cycle after acceptance. With grant always high, a two-write transaction occupies 2 cycles and a one-write transaction occupies 1 cycle.
- Throughput with rf_grant tied high: back-to-back acceptance with no bubbles, giving one write per cycle.
- wb_done pulses in the cycle after the final grant. For a zero-write transaction it pulses in the cycle after acceptance.
- rf_grant arriving while rf_we=0 is ignored.

## Structure
- Shared package `rapids_pkg`: the FSM state enum (IDLE/WR1/WR2), DATA_W/ADDR_W defaults, and the ZERO_REG constant.
- Single module, no sub-modules. The capture register and the FSM live in one block.

## Test plan
- Y1=0x11111111→r3, Y2=0x22222222→r4, grant tied high → rf_we in 2 consecutive cycles (r3, then r4); wb_done the next cycle; in_ready stays high.
- en1=1 dest1=0, en2=1 dest2=7, Y2=0xDEADBEEF → single write r7=0xDEADBEEF one cycle after accept; no write to r0.
- rf_grant held low 3 cycles during WR1 → rf_waddr/rf_wdata stable for 4 cycles; in_ready low throughout; WR2 follows the grant.
- dest1=dest2=5, Y1=1, Y2=2 → writes r5=1 then r5=2, in that order.
- Three transactions offered back-to-back with grant high → 6 writes in 6 consecutive cycles, no bubbles.
- rst asserted while in WR2 with grant low → next cycle rf_we=0, busy=0, in_ready=1; the pending write is never issued.

Source files
------------

// File: rtl/rapids_pkg.sv
// Shared definitions for the ALU writeback path: FSM states, default widths
// and the hardwired zero register index.
package rapids_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int ZERO_REG   = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR1  = 2'd1,
        WR2  = 2'd2
    } wb_state_e;

endpackage

// File: rtl/alu_writeback.sv
// Serialises one ALU result pair (Y1 then Y2) onto the single register-file write port.
// Latency: first rf_we one cycle after acceptance; one write per granted cycle.
// Backpressure: in_ready only in IDLE or while the final write of a transaction is granted.
module alu_writeback
    import rapids_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] Y1,
    input  logic [DATA_W-1:0] Y2,
    input  logic              en1,
    input  logic              en2,
    input  logic [ADDR_W-1:0] dest1,
    input  logic [ADDR_W-1:0] dest2,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic              rf_grant,
    output logic              wb_done,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    wb_state_e         state;
    logic [DATA_W-1:0] y2_q;
    logic [ADDR_W-1:0] dest2_q;
    logic              w2_q;

    logic w1;
    logic w2;
    logic final_grant;
    logic accept;

    // Writes aimed at r0 are dropped up front so they never occupy a port cycle.
    assign w1 = en1 && (dest1 != ZERO_ADDR);
    assign w2 = en2 && (dest2 != ZERO_ADDR);

    assign final_grant = rf_grant && ((state == WR2) || ((state == WR1) && !w2_q));
    assign in_ready    = (state == IDLE) || final_grant;
    assign accept      = in_valid && in_ready;
    assign busy        = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            wb_done  <= 1'b0;
            y2_q     <= '0;
            dest2_q  <= '0;
            w2_q     <= 1'b0;
        end else begin
            wb_done <= final_grant || (accept && !w1 && !w2);

            if (accept) begin
                y2_q    <= Y2;
                dest2_q <= dest2;
                w2_q    <= w2;
                if (w1) begin
                    state    <= WR1;
                    rf_we    <= 1'b1;
                    rf_waddr <= dest1;
                    rf_wdata <= Y1;
                end else if (w2) begin
                    state    <= WR2;
                    rf_we    <= 1'b1;
                    rf_waddr <= dest2;
                    rf_wdata <= Y2;
                end else begin
                    state <= IDLE;
                    rf_we <= 1'b0;
                end
            end else if ((state == WR1) && rf_grant && w2_q) begin
                state    <= WR2;
                rf_waddr <= dest2_q;
                rf_wdata <= y2_q;
            end else if (final_grant) begin
                state <= IDLE;
                rf_we <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_writeback.sv
// Bench for alu_writeback: vector table plus hand-written stall, back-to-back
// and mid-transaction reset sequences, checked against a write scoreboard.
module tb_alu_writeback;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] Y1 = '0;
    logic [DW-1:0] Y2 = '0;
    logic          en1 = 1'b0;
    logic          en2 = 1'b0;
    logic [AW-1:0] dest1 = '0;
    logic [AW-1:0] dest2 = '0;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          rf_grant = 1'b1;
    logic          wb_done;
    logic          busy;

    alu_writeback #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .Y1(Y1), .Y2(Y2), .en1(en1), .en2(en2), .dest1(dest1), .dest2(dest2),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rf_grant(rf_grant), .wb_done(wb_done), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    typedef struct {
        logic [DW-1:0] y1;
        logic [DW-1:0] y2;
        logic          e1;
        logic          e2;
        logic [AW-1:0] d1;
        logic [AW-1:0] d2;
        int            nw;
    } vec_t;

    wr_t  exp_q[$];
    int   wr_cyc[$];
    wr_t  e_m;
    int   cyc = 0;
    int   done_cnt = 0;
    int   done_exp = 0;
    int   checks = 0;
    int   errors = 0;
    vec_t vt[7];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every granted write must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst) begin
            if (wb_done === 1'b1) done_cnt++;
            if (rf_we === 1'b1 && rf_grant === 1'b1) begin
                wr_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got r%0d=%h expected no write", rf_waddr, rf_wdata);
                end else begin
                    e_m = exp_q.pop_front();
                    chk("wr_addr", 64'(rf_waddr), 64'(e_m.a));
                    chk("wr_data", 64'(rf_wdata), 64'(e_m.d));
                end
            end
        end
    end

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic send(input logic [DW-1:0] y1v, input logic [DW-1:0] y2v,
                        input logic e1, input logic e2,
                        input logic [AW-1:0] d1, input logic [AW-1:0] d2);
        logic acc;
        bit   ok;
        wr_t  w;
        Y1 = y1v; Y2 = y2v; en1 = e1; en2 = e2; dest1 = d1; dest2 = d2;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) ok = 1'b1;
        end
        in_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL accept_timeout: got no accept expected accept within 50 cycles");
        end else begin
            if (e1 && d1 != 0) begin w.a = d1; w.d = y1v; exp_q.push_back(w); end
            if (e2 && d2 != 0) begin w.a = d2; w.d = y2v; exp_q.push_back(w); end
            done_exp++;
        end
    endtask

    initial begin
        vt[0] = '{32'h11111111, 32'h22222222, 1'b1, 1'b1, 5'd3,  5'd4,  2};
        vt[1] = '{32'h0BADF00D, 32'hDEADBEEF, 1'b1, 1'b1, 5'd0,  5'd7,  1};
        vt[2] = '{32'h00000001, 32'h00000002, 1'b1, 1'b1, 5'd5,  5'd5,  2};
        vt[3] = '{32'hAAAA5555, 32'h12345678, 1'b1, 1'b0, 5'd9,  5'd10, 1};
        vt[4] = '{32'hCAFEBABE, 32'hFEEDFACE, 1'b0, 1'b1, 5'd8,  5'd31, 1};
        vt[5] = '{32'h33333333, 32'h44444444, 1'b1, 1'b0, 5'd0,  5'd6,  0};
        vt[6] = '{32'h55555555, 32'h66666666, 1'b0, 1'b0, 5'd2,  5'd3,  0};

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_we", 64'(rf_we), 64'd0);
        chk("rst_waddr", 64'(rf_waddr), 64'd0);
        chk("rst_wdata", 64'(rf_wdata), 64'd0);
        chk("rst_done", 64'(wb_done), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // Table-driven vectors with grant tied high
        for (int v = 0; v < 7; v++) begin
            send(vt[v].y1, vt[v].y2, vt[v].e1, vt[v].e2, vt[v].d1, vt[v].d2);
            for (int k = 0; k < vt[v].nw; k++) begin
                @(negedge clk);
                chk($sformatf("vec%0d_we%0d", v, k), 64'(rf_we), 64'd1);
            end
            @(negedge clk);
            chk($sformatf("vec%0d_done", v), 64'(wb_done), 64'd1);
            chk($sformatf("vec%0d_idle_we", v), 64'(rf_we), 64'd0);
            chk($sformatf("vec%0d_busy", v), 64'(busy), 64'd0);
            chk($sformatf("vec%0d_ready", v), 64'(in_ready), 64'd1);
            @(posedge clk); #1;
        end
        chk("vec_done_count", 64'(done_cnt), 64'(done_exp));
        chk("vec_sb_empty", 64'(exp_q.size()), 64'd0);

        // Grant stall during WR1: outputs held, in_ready low
        rf_grant = 1'b0;
        send(32'hA5A5A5A5, 32'h5A5A5A5A, 1'b1, 1'b1, 5'd11, 5'd12);
        for (int k = 0; k < 4; k++) begin
            if (k == 3) rf_grant = 1'b1;
            @(negedge clk);
            chk($sformatf("stall_we%0d", k), 64'(rf_we), 64'd1);
            chk($sformatf("stall_addr%0d", k), 64'(rf_waddr), 64'd11);
            chk($sformatf("stall_data%0d", k), 64'(rf_wdata), 64'hA5A5A5A5);
            chk($sformatf("stall_ready%0d", k), 64'(in_ready), 64'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("stall_wr2_addr", 64'(rf_waddr), 64'd12);
        chk("stall_wr2_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("stall_done", 64'(wb_done), 64'd1);
        @(posedge clk); #1;

        // Three back-to-back two-write transactions: six writes, no bubbles
        wr_cyc.delete();
        send(32'h00000101, 32'h00000102, 1'b1, 1'b1, 5'd1, 5'd2);
        send(32'h00000201, 32'h00000202, 1'b1, 1'b1, 5'd13, 5'd14);
        send(32'h00000301, 32'h00000302, 1'b1, 1'b1, 5'd15, 5'd16);
        repeat (4) @(negedge clk);
        chk("b2b_count", 64'(wr_cyc.size()), 64'd6);
        for (int i = 1; i < wr_cyc.size(); i++)
            chk($sformatf("b2b_gap%0d", i), 64'(wr_cyc[i] - wr_cyc[i-1]), 64'd1);
        chk("b2b_done_count", 64'(done_cnt), 64'(done_exp));
        @(posedge clk); #1;

        // Reset in WR2 with grant low: pending write discarded
        send(32'h77777777, 32'h88888888, 1'b1, 1'b1, 5'd20, 5'd21);
        @(posedge clk); #1;
        rf_grant = 1'b0;
        @(negedge clk);
        chk("rstmid_wr2_we", 64'(rf_we), 64'd1);
        chk("rstmid_wr2_addr", 64'(rf_waddr), 64'd21);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        done_exp--;
        @(negedge clk);
        chk("rstmid_we", 64'(rf_we), 64'd0);
        chk("rstmid_busy", 64'(busy), 64'd0);
        chk("rstmid_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        rf_grant = 1'b1;
        repeat (4) @(negedge clk);
        chk("rstmid_done_count", 64'(done_cnt), 64'(done_exp));
        @(posedge clk); #1;

        // Recovery after reset
        send(32'h99999999, 32'h0, 1'b1, 1'b0, 5'd22, 5'd0);
        @(negedge clk);
        chk("post_rst_we", 64'(rf_we), 64'd1);
        repeat (3) @(negedge clk);
        chk("final_done_count", 64'(done_cnt), 64'(done_exp));
        chk("final_sb_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
